t_flipflop_bank: RTL and testbench
==================================

Name: t_flipflop_bank

Overview:
- Parametrised successor to the single-bit T flip-flop.
- Holds a WIDTH-bit bank of T flip-flops with four run-time modes:
  - independent per-bit toggle
  - chained toggle, which forms a synchronous modulo counter
  - parallel load
  - hold
- Registered true and complement outputs, a terminal-count pulse and a change flag.
- Used as a reusable toggle/count register wherever the design needs divided clocks-as-enables, event counters or toggle state.

Parameters:
- WIDTH, 4, number of flip-flops in the bank (1..32).
- RST_VAL, 0, value of q after reset (WIDTH bits).
- CNT_MAX, 2**WIDTH-1, highest count in chained mode; the counter wraps to 0 after this value.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- mode  input  2  operating mode: 00 toggle, 01 chain/count, 10 load, 11 hold.
- t  input  WIDTH  per-bit toggle enables; in chain mode only t[0] is used, as the count enable.
- d  input  WIDTH  parallel load data.
- q  output  WIDTH  registered state.
- q_bar  output  WIDTH  registered complement; always equal to ~q.
- tc  output  1  one-cycle terminal-count pulse.
- changed  output  1  high for one cycle when q changed on the previous edge.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst. All state updates occur on the rising edge of clk; there are no combinational input-to-output paths.
- Reset (rst=1 at the edge) overrides every mode:
  - q=RST_VAL, q_bar=~RST_VAL
  - tc=0, changed=0
  - Inputs are ignored during reset.
  - Reset asserted mid-count takes effect at the same edge, with no completion of the pending update.
- Mode 00, toggle: q_next = q ^ t. Bits with t=0 hold. t=all-ones inverts the whole bank.
- Mode 01, chain/count: when t[0]=1, advance the counter:
  - if q >= CNT_MAX, then q_next=0 and tc=1 on the following cycle;
  - otherwise q_next = q+1 (modulo 2**WIDTH arithmetic, with no overflow beyond WIDTH).
  - When t[0]=0, q holds.
  - Values above CNT_MAX (for example from a load) wrap to 0 at the next enabled count and assert tc.
- Mode 10, load: q_next=d. Load takes priority over t.
- Mode 11, hold: q unchanged; t and d are ignored.
- tc is registered and high for exactly one cycle per wrap. It is 0 in all modes other than 01.
- changed is registered: changed = (q_next != q), evaluated at each edge. It is 0 at the first edge after reset is released if q is not modified.
- Latency: q, q_bar, tc and changed all reflect the inputs sampled at edge N, and are visible after edge N.
- A mode change takes effect at the edge on which the new mode is sampled. Counter state carries over unchanged between modes.

Optional Feature:
- Macro: TFF_BANK_PARITY_EN.
- When defined:
  - adds output parity (1 bit), a registered XOR-reduction of q_next, so parity always equals ^q;
  - reset value is ^RST_VAL;
  - also adds the input parity_err_inj (1 bit); when this is high, the stored parity is inverted for that cycle's update, for checker testing.
- When undefined: neither port exists, no parity logic is present, and all other behaviour is identical.

Test Plan:
All scenarios use WIDTH=4, RST_VAL=0 and CNT_MAX=15 unless stated otherwise.
- Reset: rst=1 for 2 edges with mode=01 and t=4'hF -> q=4'h0, q_bar=4'hF, tc=0, changed=0. Releasing rst with mode=11 -> q stays 0, changed=0.
- Toggle: mode=00; t=4'b0101, then 4'b0101, then 4'b0000, then 4'b1111 -> q=5, 0, 0, F. changed=1, 1, 0, 1. q_bar=~q at every step.
- Count and wrap: mode=01, t[0]=1 for 17 edges from 0 -> q walks 1..15, then 0, then 1. tc=1 only in the cycle after the 15->0 edge. Clearing t[0] mid-count holds q and sets changed=0.
- CNT_MAX=9: counting from 0 -> q goes 0..9 then 0, with tc pulsing once per 10 counts. Loading d=4'hC, then counting -> q=0 and tc=1 after the next edge.
- Mixed: load d=4'hA (mode=10, t=4'hF) -> q=A. Then mode=11 for 3 edges -> q=A and changed=0. Asserting rst during mode=01 at q=7 -> q=0 at that edge, tc=0.
- With TFF_BANK_PARITY_EN: after loading d=4'b0111 -> parity=1. Pulsing parity_err_inj for one edge -> parity differs from ^q for exactly that cycle.

Source files
------------

// File: rtl/t_flipflop_bank.sv
// t_flipflop_bank: WIDTH-bit T flip-flop bank with toggle, chained count, load and hold modes.
// Optional registered parity output and error injection when TFF_BANK_PARITY_EN is defined.
module t_flipflop_bank #(
    parameter int unsigned       WIDTH   = 4,
    parameter logic [WIDTH-1:0]  RST_VAL = '0,
    parameter logic [WIDTH-1:0]  CNT_MAX = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic             changed
`ifdef TFF_BANK_PARITY_EN
    ,
    input  logic             parity_err_inj,
    output logic             parity
`endif
);
    localparam logic [1:0] M_TOG = 2'b00;
    localparam logic [1:0] M_CNT = 2'b01;
    localparam logic [1:0] M_LD  = 2'b10;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_q_bar;
    logic             r_tc;
    logic             r_changed;
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap;
    // Counts at or above CNT_MAX (e.g. after a load) wrap to zero on the next enabled count.
    always_comb begin
        w_wrap   = (mode == M_CNT) && t[0] && (r_q >= CNT_MAX);
        w_q_next = (mode == M_TOG) ? r_q ^ t :
                   (mode == M_CNT) ? (t[0] ? (w_wrap ? '0 : r_q + WIDTH'(1)) : r_q) :
                   (mode == M_LD)  ? d : r_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= RST_VAL;
            r_q_bar   <= ~RST_VAL;
            r_tc      <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            r_q       <= w_q_next;
            r_q_bar   <= ~w_q_next;
            r_tc      <= w_wrap;
            r_changed <= (w_q_next != r_q);
        end
    end
    assign q       = r_q;
    assign q_bar   = r_q_bar;
    assign tc      = r_tc;
    assign changed = r_changed;
`ifdef TFF_BANK_PARITY_EN
    logic r_parity;
    always_ff @(posedge clk) begin
        if (rst) r_parity <= ^RST_VAL;
        else     r_parity <= (^w_q_next) ^ parity_err_inj;
    end
    assign parity = r_parity;
`endif
endmodule

// File: tb/tb_t_flipflop_bank.sv
// tb_t_flipflop_bank: directed vector table, hand sequences and randomized run against a reference model.
// Two instances: default CNT_MAX=15 and CNT_MAX=9.
module tb_t_flipflop_bank;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [3:0] t, d;
    logic [3:0] q_o [2];
    logic [3:0] qb_o [2];
    logic       tc_o [2];
    logic       ch_o [2];
    logic       inj;
    logic       par_o [2];
    int checks = 0;
    int errors = 0;
    int mq [2];
    int mtc [2];
    int mch [2];
    int mpar [2];
    int maxv [2] = '{15, 9};

    always #5 clk = ~clk;

    t_flipflop_bank #(.WIDTH(4), .RST_VAL(4'h0), .CNT_MAX(4'd15)) dut (
        .clk(clk), .rst(rst), .mode(mode), .t(t), .d(d),
        .q(q_o[0]), .q_bar(qb_o[0]), .tc(tc_o[0]), .changed(ch_o[0])
`ifdef TFF_BANK_PARITY_EN
        , .parity_err_inj(inj), .parity(par_o[0])
`endif
    );
    t_flipflop_bank #(.WIDTH(4), .RST_VAL(4'h0), .CNT_MAX(4'd9)) dut9 (
        .clk(clk), .rst(rst), .mode(mode), .t(t), .d(d),
        .q(q_o[1]), .q_bar(qb_o[1]), .tc(tc_o[1]), .changed(ch_o[1])
`ifdef TFF_BANK_PARITY_EN
        , .parity_err_inj(inj), .parity(par_o[1])
`endif
    );

    typedef struct {
        logic       rst;
        logic [1:0] mode;
        logic [3:0] t;
        logic [3:0] d;
        logic [3:0] eq;
        logic       etc;
        logic       ech;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: next state from the mode rules using plain integer arithmetic.
    task automatic model_update(input logic r, input logic [1:0] m, input logic [3:0] tt,
                                input logic [3:0] dd, input logic ij);
        for (int k = 0; k < 2; k++) begin
            int nq;
            int ntc;
            nq = mq[k];
            ntc = 0;
            if (r) begin
                mq[k] = 0; mtc[k] = 0; mch[k] = 0; mpar[k] = 0;
            end else begin
                if (m == 2'd0) nq = mq[k] ^ int'(tt);
                else if (m == 2'd1 && tt[0]) begin
                    if (mq[k] >= maxv[k]) begin nq = 0; ntc = 1; end
                    else nq = (mq[k] + 1) % 16;
                end else if (m == 2'd2) nq = int'(dd);
                mch[k] = (nq != mq[k]) ? 1 : 0;
                mtc[k] = ntc;
                mq[k] = nq;
                mpar[k] = ($countones(nq) % 2) ^ int'(ij);
            end
        end
    endtask

    task automatic step(input logic r, input logic [1:0] m, input logic [3:0] tt,
                        input logic [3:0] dd, input logic ij);
        rst = r; mode = m; t = tt; d = dd; inj = ij;
        @(posedge clk);
        #1;
        model_update(r, m, tt, dd, ij);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("q[%0d]", k), 32'(q_o[k]), 32'(mq[k]));
            check($sformatf("q_bar[%0d]", k), 32'(qb_o[k]), 32'(~mq[k] & 15));
            check($sformatf("tc[%0d]", k), 32'(tc_o[k]), 32'(mtc[k]));
            check($sformatf("changed[%0d]", k), 32'(ch_o[k]), 32'(mch[k]));
`ifdef TFF_BANK_PARITY_EN
            check($sformatf("parity[%0d]", k), 32'(par_o[k]), 32'(mpar[k]));
`endif
        end
    endtask

    initial begin
        vec_t vt [12];
        vt = '{
            '{1'b1, 2'd1, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0},
            '{1'b1, 2'd1, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0},
            '{1'b0, 2'd3, 4'hF, 4'h5, 4'h0, 1'b0, 1'b0},
            '{1'b0, 2'd0, 4'h5, 4'h0, 4'h5, 1'b0, 1'b1},
            '{1'b0, 2'd0, 4'h5, 4'h0, 4'h0, 1'b0, 1'b1},
            '{1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0},
            '{1'b0, 2'd0, 4'hF, 4'h0, 4'hF, 1'b0, 1'b1},
            '{1'b0, 2'd2, 4'hF, 4'hA, 4'hA, 1'b0, 1'b1},
            '{1'b0, 2'd3, 4'hF, 4'h3, 4'hA, 1'b0, 1'b0},
            '{1'b0, 2'd3, 4'hF, 4'h3, 4'hA, 1'b0, 1'b0},
            '{1'b0, 2'd3, 4'hF, 4'h3, 4'hA, 1'b0, 1'b0},
            '{1'b0, 2'd2, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1}
        };
        rst = 1'b1; mode = 2'd1; t = 4'hF; d = 4'h0; inj = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(vt[i].rst, vt[i].mode, vt[i].t, vt[i].d, 1'b0);
            check($sformatf("vec%0d q", i), 32'(q_o[0]), 32'(vt[i].eq));
            check($sformatf("vec%0d tc", i), 32'(tc_o[0]), 32'(vt[i].etc));
            check($sformatf("vec%0d changed", i), 32'(ch_o[0]), 32'(vt[i].ech));
        end
        // 17 counts from 0: 1..15, wrap to 0 with tc, then 1
        for (int i = 1; i <= 17; i++) begin
            step(1'b0, 2'd1, 4'h1, 4'h0, 1'b0);
            check("count q", 32'(q_o[0]), 32'(i % 16));
            check("count tc", 32'(tc_o[0]), (i == 16) ? 32'd1 : 32'd0);
        end
        step(1'b0, 2'd1, 4'hE, 4'h0, 1'b0);
        check("count hold q", 32'(q_o[0]), 32'd1);
        check("count hold changed", 32'(ch_o[0]), 32'd0);
        // above-CNT_MAX load wraps on the CNT_MAX=9 instance only
        step(1'b0, 2'd2, 4'hF, 4'hC, 1'b0);
        step(1'b0, 2'd1, 4'h1, 4'h0, 1'b0);
        check("wrap9 q", 32'(q_o[1]), 32'd0);
        check("wrap9 tc", 32'(tc_o[1]), 32'd1);
        check("nowrap15 q", 32'(q_o[0]), 32'hD);
        // reset mid-count at q=7
        step(1'b0, 2'd2, 4'h0, 4'h6, 1'b0);
        step(1'b0, 2'd1, 4'h1, 4'h0, 1'b0);
        check("pre-rst q", 32'(q_o[0]), 32'd7);
        step(1'b1, 2'd1, 4'hF, 4'hF, 1'b0);
        check("rst mid q", 32'(q_o[0]), 32'd0);
        check("rst mid tc", 32'(tc_o[0]), 32'd0);
        // 10 counts on CNT_MAX=9 produce exactly one tc pulse
        begin
            int pulses = 0;
            for (int i = 0; i < 10; i++) begin
                step(1'b0, 2'd1, 4'h1, 4'h0, 1'b0);
                pulses += int'(tc_o[1]);
            end
            check("tc9 pulses", 32'(pulses), 32'd1);
        end
`ifdef TFF_BANK_PARITY_EN
        step(1'b0, 2'd2, 4'h0, 4'h7, 1'b0);
        check("parity load7", 32'(par_o[0]), 32'd1);
        step(1'b0, 2'd3, 4'h0, 4'h0, 1'b1);
        check("parity inj differs", 32'(par_o[0] ^ (^q_o[0])), 32'd1);
        step(1'b0, 2'd3, 4'h0, 4'h0, 1'b0);
        check("parity restored", 32'(par_o[0] ^ (^q_o[0])), 32'd0);
`endif
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)), 4'($urandom),
                 4'($urandom), ($urandom_range(0, 7) == 0));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
